// File: rtl/dcache_blocking_pkg.sv
// Shared types for the blocking data cache and its backing memory.
//   addr_t          byte address
//   ram_dat_dat_t   one bus beat of line data
//   mem_state_t     sequencing states of dcache_mem_model
//   MEM_LAT         default fill latency (idle cycles before the first beat)
//   MEM_LINES       default backing depth in lines
package dcache_blocking_pkg;

   localparam int ADDR_W = 32;
   localparam int BEAT_W = 128;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [BEAT_W-1:0] ram_dat_dat_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_WAIT = 2'd2,
      RD      = 2'd3
   } mem_state_t;

   localparam int MEM_LAT   = 4;
   localparam int MEM_LINES = 256;

endpackage

// File: rtl/dcache_mem_model_ram.sv
// Word array behind dcache_mem_model: one synchronous write port and one
// registered read port.
//   clk, rst      clock, synchronous active-high reset (read register only)
//   wr_en/addr/data  write port, takes effect at the clock edge
//   rd_en/addr    read request; rd_data updates at the following edge
//   rd_data       registered read data, 0 after reset
// The array itself is never reset, so contents survive rst.
module dcache_mem_model_ram #(
   parameter int AW = 10,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/dcache_mem_model.sv
// Line-granular backing memory downstream of dcache_blocking. Accepts line
// write-backs and fill requests on dcache__mem_*, returns fill lines on
// mem__dcache_* a fixed LAT idle cycles after the request.
//   clk, rst                 clock, synchronous active-high reset
//   dcache__mem_valid_r      request strobe; addr/wrbk qualify it
//   dcache__mem_dat_*        write-back beats (valid/sop/eop/data)
//   mem__dcache_*            fill beats (valid/sop/eop/data), all registered
//   mem__busy_r              request in progress
//   mem__proto_err_r         sticky protocol error; only built when
//                            DCACHE_MEM_MODEL_PROTO_CHK_EN is defined,
//                            otherwise tied to 0
//
// state   | meaning
// IDLE    | waiting for a request
// WR      | accepting write-back beats into the latched line
// RD_WAIT | counting down fill latency; last cycle reads beat 0
// RD      | presenting fill beats, reading one beat ahead
module dcache_mem_model #(
   parameter int ADDR_W = dcache_blocking_pkg::ADDR_W,
   parameter int BEAT_W = dcache_blocking_pkg::BEAT_W,
   parameter int BEATS  = 4,
   parameter int LINES  = dcache_blocking_pkg::MEM_LINES,
   parameter int LAT    = dcache_blocking_pkg::MEM_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dcache__mem_valid_r,
   input  logic [ADDR_W-1:0] dcache__mem_addr_r,
   input  logic              dcache__mem_wrbk_r,
   input  logic              dcache__mem_dat_valid_r,
   input  logic              dcache__mem_sop_r,
   input  logic              dcache__mem_eop_r,
   input  logic [BEAT_W-1:0] dcache__mem_dat_r,
   output logic              mem__dcache_valid_w,
   output logic              mem__dcache_sop_w,
   output logic              mem__dcache_eop_w,
   output logic [BEAT_W-1:0] mem__dcache_data_w,
   output logic              mem__busy_r,
   output logic              mem__proto_err_r
);

   import dcache_blocking_pkg::*;

   localparam int OFF_W = $clog2(BEATS*BEAT_W/8);
   localparam int IDX_W = $clog2(LINES);
   localparam int BCW   = $clog2(BEATS);
   localparam int LCW   = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [BCW-1:0] LAST_BEAT   = BCW'(BEATS-1);
   localparam logic [BCW-1:0] PENULT_BEAT = BCW'(BEATS-2);
   localparam logic [LCW-1:0] LAT_LOAD    = LCW'(LAT-1);

   mem_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [BCW-1:0]   beat_q;
   logic [LCW-1:0]   lat_q;
   logic             valid_q, sop_q, eop_q, busy_q;
   logic             valid_d, sop_d, eop_d;

   logic [IDX_W-1:0] req_idx;
   logic             wr_first, wr_beat_en, wr_done, wr_en;
   logic [BCW-1:0]   wr_beat, rd_beat;
   logic [IDX_W+BCW-1:0] wr_addr, rd_addr;
   logic             rd_en;

   // Offset and upper address bits are deliberately dropped (line aliasing).
   logic unused_addr_bits;
   assign unused_addr_bits = ^dcache__mem_addr_r;

   assign req_idx = dcache__mem_addr_r[OFF_W +: IDX_W];

   // A beat arriving with the write-back request itself is beat 0.
   assign wr_first   = (state_q == IDLE) && dcache__mem_valid_r && dcache__mem_wrbk_r
                       && dcache__mem_dat_valid_r;
   assign wr_beat_en = (state_q == WR) && dcache__mem_dat_valid_r;
   assign wr_beat    = dcache__mem_sop_r ? '0 : beat_q;
   assign wr_done    = wr_beat_en && (dcache__mem_eop_r || (wr_beat == LAST_BEAT));
   assign wr_en      = !rst && (wr_first || wr_beat_en);
   assign wr_addr    = wr_first ? {req_idx, {BCW{1'b0}}} : {idx_q, wr_beat};
   assign rd_addr    = {idx_q, rd_beat};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (dcache__mem_valid_r) state_d = dcache__mem_wrbk_r ? WR : RD_WAIT;
         WR:      if (wr_done) state_d = IDLE;
         RD_WAIT: if (lat_q == '0) state_d = RD;
         RD:      if (beat_q == LAST_BEAT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read data is registered in the RAM, so each read is issued one cycle
   // before its beat is presented.
   always_comb begin
      rd_en   = 1'b0;
      rd_beat = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      case (state_q)
         RD_WAIT: begin
            if (lat_q == '0) begin
               rd_en = 1'b1;
               sop_d = 1'b1;
            end
         end
         RD: begin
            if (beat_q != LAST_BEAT) begin
               rd_en   = 1'b1;
               rd_beat = beat_q + BCW'(1);
               eop_d   = (beat_q == PENULT_BEAT);
            end
         end
         default: ;
      endcase
      valid_d = rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         busy_q  <= (state_d != IDLE);
         case (state_q)
            IDLE: begin
               if (dcache__mem_valid_r) begin
                  idx_q  <= req_idx;
                  lat_q  <= LAT_LOAD;
                  beat_q <= wr_first ? BCW'(1) : '0;
               end
            end
            WR: begin
               if (wr_beat_en) beat_q <= wr_beat + BCW'(1);
            end
            RD_WAIT: begin
               if (lat_q != '0) lat_q <= lat_q - LCW'(1);
               else beat_q <= '0;
            end
            RD: beat_q <= beat_q + BCW'(1);
            default: ;
         endcase
      end
   end

   dcache_mem_model_ram #(
      .AW(IDX_W+BCW),
      .DW(BEAT_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (dcache__mem_dat_r),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (mem__dcache_data_w)
   );

   assign mem__dcache_valid_w = valid_q;
   assign mem__dcache_sop_w   = sop_q;
   assign mem__dcache_eop_w   = eop_q;
   assign mem__busy_r         = busy_q;

`ifdef DCACHE_MEM_MODEL_PROTO_CHK_EN
   logic           proto_q, proto_hit, wr_take;
   logic [BCW-1:0] eff_beat;

   always_comb begin
      wr_take   = wr_first || wr_beat_en;
      eff_beat  = wr_first ? '0 : wr_beat;
      proto_hit = 1'b0;
      if (dcache__mem_valid_r && (state_q != IDLE)) proto_hit = 1'b1;
      if (dcache__mem_dat_valid_r && !wr_take) proto_hit = 1'b1;
      if (wr_beat_en && dcache__mem_sop_r && (beat_q != '0)) proto_hit = 1'b1;
      if (wr_take && dcache__mem_eop_r && (eff_beat != LAST_BEAT)) proto_hit = 1'b1;
      if (wr_take && !dcache__mem_eop_r && (eff_beat == LAST_BEAT)) proto_hit = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_q <= 1'b0;
      end else if (proto_hit) begin
         proto_q <= 1'b1;
      end
   end

   assign mem__proto_err_r = proto_q;
`else
   assign mem__proto_err_r = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_mem_model.sv
`timescale 1ns/1ps
module tb_dcache_mem_model;

   localparam int ADDR_W = 32;
   localparam int BEAT_W = 128;
   localparam int BEATS  = 4;
   localparam int LINES  = 256;
   localparam int LAT    = 4;
   localparam int BIG    = 1000000;
   localparam int HIST   = 4096;
`ifdef DCACHE_MEM_MODEL_PROTO_CHK_EN
   localparam bit PROTO = 1'b1;
`else
   localparam bit PROTO = 1'b0;
`endif

   localparam logic [127:0] A0 = {4{32'hA0A0_0000}};
   localparam logic [127:0] A1 = {4{32'hA1A1_0001}};
   localparam logic [127:0] A2 = {4{32'hA2A2_0002}};
   localparam logic [127:0] A3 = {4{32'hA3A3_0003}};
   localparam logic [127:0] B0 = {4{32'hB0B0_1000}};
   localparam logic [127:0] B1 = {4{32'hB1B1_1001}};
   localparam logic [127:0] B2 = {4{32'hB2B2_1002}};
   localparam logic [127:0] B3 = {4{32'hB3B3_1003}};
   localparam logic [127:0] C0 = {4{32'hC0C0_2000}};
   localparam logic [127:0] C1 = {4{32'hC1C1_2001}};
   localparam logic [127:0] C2 = {4{32'hC2C2_2002}};
   localparam logic [127:0] C3 = {4{32'hC3C3_2003}};

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              req_wrbk = 1'b0;
   logic              dat_valid = 1'b0;
   logic              dat_sop = 1'b0;
   logic              dat_eop = 1'b0;
   logic [BEAT_W-1:0] dat = '0;
   logic              fill_valid, fill_sop, fill_eop, busy, proto_err;
   logic [BEAT_W-1:0] fill_data;

   dcache_mem_model #(
      .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .LINES(LINES), .LAT(LAT)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .dcache__mem_valid_r     (req_valid),
      .dcache__mem_addr_r      (req_addr),
      .dcache__mem_wrbk_r      (req_wrbk),
      .dcache__mem_dat_valid_r (dat_valid),
      .dcache__mem_sop_r       (dat_sop),
      .dcache__mem_eop_r       (dat_eop),
      .dcache__mem_dat_r       (dat),
      .mem__dcache_valid_w     (fill_valid),
      .mem__dcache_sop_w       (fill_sop),
      .mem__dcache_eop_w       (fill_eop),
      .mem__dcache_data_w      (fill_data),
      .mem__busy_r             (busy),
      .mem__proto_err_r        (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Behavioural model: line store plus the time windows in which the
   // memory must be busy or presenting fill beats.
   logic [127:0] mmem  [LINES*BEATS];
   bit           known [LINES*BEATS];
   int busy_from = 0, busy_to = 0;
   int fill_start = -BIG, fill_idx = 0, fill_cut = 0;
   bit m_wr = 1'b0;
   int m_idx = 0, m_beat = 0;
   int p_set = BIG, p_clr = 0;
   bit chk_en = 1'b0;

   bit vh [HIST];
   bit sh [HIST];
   bit eh [HIST];
   bit bh [HIST];
   bit ph [HIST];
   logic [127:0] got_q [$];

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int line_of(input logic [31:0] a);
      return int'((a / 64) % LINES);
   endfunction

   function automatic bit proto_raw(input int c);
      return (p_set <= c) && !((p_clr <= c) && (p_clr > p_set));
   endfunction

   function automatic bit exp_proto(input int c);
      return PROTO && proto_raw(c);
   endfunction

   task automatic mark_proto(input int c);
      if (!proto_raw(c + 1)) p_set = c + 1;
   endtask

   task automatic store(input int idx, input int b, input logic [127:0] d);
      mmem[idx*BEATS + b]  = d;
      known[idx*BEATS + b] = 1'b1;
   endtask

   // One bus cycle of stimulus, applied to the model and the DUT together.
   task automatic drive(input bit v, input logic [31:0] a, input bit wb,
                        input bit dv, input bit s, input bit e, input logic [127:0] d);
      int c, b;
      bit busy_now, was_wr, took;
      req_valid = v; req_addr = a; req_wrbk = wb;
      dat_valid = dv; dat_sop = s; dat_eop = e; dat = d;
      c = cyc;
      busy_now = (c > busy_from) && (c <= busy_to);
      was_wr = m_wr;
      took = 1'b0;
      if (dv && was_wr) begin
         took = 1'b1;
         if (s && m_beat != 0) mark_proto(c);
         b = s ? 0 : m_beat;
         store(m_idx, b, d);
         m_beat = b + 1;
         if (e && b != BEATS-1) mark_proto(c);
         if (!e && b == BEATS-1) mark_proto(c);
         if (e || b == BEATS-1) begin
            m_wr = 1'b0;
            busy_to = c;
         end
      end
      if (v) begin
         if (busy_now) begin
            mark_proto(c);
         end else begin
            busy_from = c;
            if (wb) begin
               m_wr = 1'b1; m_idx = line_of(a); m_beat = 0; busy_to = BIG;
               if (dv) begin
                  took = 1'b1;
                  store(m_idx, 0, d);
                  m_beat = 1;
                  if (e) mark_proto(c);
               end
            end else begin
               fill_idx = line_of(a);
               fill_start = c + LAT + 1;
               fill_cut = BIG;
               busy_to = c + LAT + BEATS;
            end
         end
      end
      if (dv && !took) mark_proto(c);
      @(posedge clk); #1;
      req_valid = 1'b0; req_wrbk = 1'b0;
      dat_valid = 1'b0; dat_sop = 1'b0; dat_eop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 32'h0, 0, 0, 0, 0, 128'h0);
   endtask

   task automatic do_reset(input int n);
      int c;
      c = cyc;
      rst = 1'b1;
      if (busy_to > c) busy_to = c;
      if (fill_cut > c) fill_cut = c;
      m_wr = 1'b0;
      p_clr = c + 1;
      repeat (n) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   task automatic write_line(input logic [31:0] a, input logic [127:0] d0, input logic [127:0] d1,
                             input logic [127:0] d2, input logic [127:0] d3);
      drive(1, a, 1, 0, 0, 0, 128'h0);
      drive(0, 32'h0, 0, 1, 1, 0, d0);
      drive(0, 32'h0, 0, 1, 0, 0, d1);
      drive(0, 32'h0, 0, 1, 0, 0, d2);
      drive(0, 32'h0, 0, 1, 0, 1, d3);
   endtask

   task automatic chk_line(input string nm, input logic [127:0] e0, input logic [127:0] e1,
                           input logic [127:0] e2, input logic [127:0] e3);
      logic [127:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chki({nm, "_beats"}, got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size()) chkw(nm, got_q[i], e[i]);
         else chkw(nm, 128'bx, e[i]);
      end
   endtask

   always @(negedge clk) begin : cmp
      int c, k;
      bit ev;
      if (chk_en) begin
         c = cyc;
         k = c - fill_start;
         ev = (k >= 0) && (k < BEATS) && (c <= fill_cut);
         chk1("fill_valid", fill_valid, ev);
         chk1("fill_sop", fill_sop, ev && (k == 0));
         chk1("fill_eop", fill_eop, ev && (k == BEATS-1));
         if (ev && known[fill_idx*BEATS + k]) chkw("fill_data", fill_data, mmem[fill_idx*BEATS + k]);
         chk1("busy", busy, (c > busy_from) && (c <= busy_to));
         chk1("proto_err", proto_err, exp_proto(c));
         if (c < HIST) begin
            vh[c] = fill_valid; sh[c] = fill_sop; eh[c] = fill_eop;
            bh[c] = busy; ph[c] = proto_err;
         end
         if (fill_valid === 1'b1) got_q.push_back(fill_data);
      end
   end

   initial begin : main
      int t, e;
      do_reset(3);
      chk_en = 1'b1;
      chk1("rst_valid", fill_valid, 1'b0);
      chk1("rst_sop", fill_sop, 1'b0);
      chk1("rst_eop", fill_eop, 1'b0);
      chkw("rst_data", fill_data, 128'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_proto", proto_err, 1'b0);

      // Fill of line 0: beats in cycles T+5..T+8.
      t = cyc;
      drive(1, 32'h0, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk1("lat_before", vh[t+4], 1'b0);
      for (int i = 5; i <= 8; i++) chk1("lat_window", vh[t+i], 1'b1);
      chk1("lat_after", vh[t+9], 1'b0);
      chk1("lat_sop", sh[t+5], 1'b1);
      chk1("lat_sop_once", sh[t+6], 1'b0);
      chk1("lat_eop", eh[t+8], 1'b1);

      // Write-back then fill, same line.
      write_line(32'h0000_0140, A0, A1, A2, A3);
      idle(2);
      got_q.delete();
      drive(1, 32'h0000_0140, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk_line("wb_fill", A0, A1, A2, A3);

      // Aliasing, with gaps between write-back beats.
      drive(1, 32'h0000_0040, 1, 0, 0, 0, 128'h0);
      drive(0, 32'h0, 0, 1, 1, 0, B0);
      idle(1);
      drive(0, 32'h0, 0, 1, 0, 0, B1);
      idle(2);
      drive(0, 32'h0, 0, 1, 0, 0, B2);
      drive(0, 32'h0, 0, 1, 0, 1, B3);
      idle(1);
      got_q.delete();
      drive(1, 32'h0000_0040 + LINES*64, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk_line("alias_fill", B0, B1, B2, B3);

      // First beat together with the request.
      drive(1, 32'h0000_0080, 1, 1, 1, 0, C0);
      drive(0, 32'h0, 0, 1, 0, 0, C1);
      drive(0, 32'h0, 0, 1, 0, 0, C2);
      e = cyc;
      drive(0, 32'h0, 0, 1, 0, 1, C3);
      idle(3);
      chk1("busy_at_eop", bh[e], 1'b1);
      chk1("busy_after_eop", bh[e+1], 1'b0);
      got_q.delete();
      drive(1, 32'h0000_0080, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk_line("same_cycle_fill", C0, C1, C2, C3);

      // Reset during the second fill beat.
      got_q.delete();
      t = cyc;
      drive(1, 32'h0000_0140, 0, 0, 0, 0, 128'h0);
      idle(5);
      do_reset(1);
      idle(4);
      chk1("rst_mid_b0", vh[t+5], 1'b1);
      chk1("rst_mid_b1", vh[t+6], 1'b1);
      chk1("rst_mid_cut", vh[t+7], 1'b0);
      chk1("rst_mid_cut2", vh[t+8], 1'b0);
      chki("rst_mid_beats", got_q.size(), 2);
      got_q.delete();
      drive(1, 32'h0000_0140, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk_line("post_rst_fill", A0, A1, A2, A3);

      // Fill request during RD_WAIT is ignored (and flagged when checking is built).
      got_q.delete();
      t = cyc;
      drive(1, 32'h0000_0080, 0, 0, 0, 0, 128'h0);
      idle(1);
      drive(1, 32'h0000_0040, 0, 0, 0, 0, 128'h0);
      idle(12);
      chk1("proto_set", ph[t+3], PROTO);
      chk1("proto_sticky", ph[t+14], PROTO);
      chk_line("ignored_req_fill", C0, C1, C2, C3);
      do_reset(2);
      idle(2);
      chk1("proto_cleared", proto_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
